// File: rtl/cmd_bank_pkg.sv
// ---------------------------------------------------------------------------
// cmd_bank_pkg
// Shared types for the command bank scheduler.
//   cmd_t   : one command entry at the default command width
//   state_t : scheduler FSM states (IDLE, ISSUE)
//   src_t   : which requester owns the active bank (SRC_A, SRC_B)
//   min_int : small helper used to clamp bank lengths to the slot count
// ---------------------------------------------------------------------------
package cmd_bank_pkg;

  localparam int CMD_W_DEFAULT = 2;

  typedef logic [CMD_W_DEFAULT-1:0] cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_bank_sched_if.sv
// ---------------------------------------------------------------------------
// cmd_bank_sched_if
// Bundles the two requester bank handshakes and the issued-command stream.
//   a_valid/a_ready/a_bank/a_len : requester A bank offer
//   b_valid/b_ready/b_bank/b_len : requester B bank offer
//   out_valid/out_ready          : issued command handshake
//   out_cmd/out_idx/out_src      : command, its slot index and its source
//   busy                         : scheduler is issuing a bank
// Modports: master = requesters + consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface cmd_bank_sched_if #(
  parameter int DEPTH = 9,
  parameter int CMD_W = 2,
  parameter int LEN_W = $clog2(DEPTH + 1)
);

  logic             a_valid;
  logic             a_ready;
  logic [CMD_W-1:0] a_bank [DEPTH-1:0];
  logic [LEN_W-1:0] a_len;

  logic             b_valid;
  logic             b_ready;
  logic [CMD_W-1:0] b_bank [DEPTH-1:0];
  logic [LEN_W-1:0] b_len;

  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;
  logic [LEN_W-1:0] out_idx;
  logic             out_src;
  logic             busy;

  modport master (
    output a_valid, a_bank, a_len,
    output b_valid, b_bank, b_len,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_cmd, out_idx, out_src, busy
  );

  modport slave (
    input  a_valid, a_bank, a_len,
    input  b_valid, b_bank, b_len,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_cmd, out_idx, out_src, busy
  );

endinterface

// File: rtl/cmd_bank_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester arbiter for the bank scheduler.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = A, bit 1 = B
//   update     : a grant was taken this cycle; remember who won
//   gnt[1:0]   : one-hot grant (or zero when nobody requests)
// Default build: round-robin, A favoured first after reset.
// With CMD_BANK_SCHED_PRIO_A_EN defined: fixed priority, A always wins and
// no grant history is kept.
// ---------------------------------------------------------------------------
module rr_arb2
  import cmd_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef CMD_BANK_SCHED_PRIO_A_EN

  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};

  // Clock, reset and update have no job in the fixed-priority policy.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, update};

`else

  src_t last_grant_reg;

  // Reset to B so that A wins the very first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= SRC_B;
    end else if (update) begin
      last_grant_reg <= gnt[1] ? SRC_B : SRC_A;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant_reg == SRC_B) ? 2'b01 : 2'b10;
    end
  end

`endif

endmodule

// File: rtl/cmd_bank_sched.sv
// ---------------------------------------------------------------------------
// cmd_bank_sched
// Accepts whole command banks from two requesters and issues the valid
// entries of the accepted bank one per out_valid/out_ready handshake.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cmd_bank_sched_if.slave (bank offers, issued command stream)
// Parameters: DEPTH slots per bank, CMD_W bits per command, LEN_W bits for
// lengths and indices.
// Build option: CMD_BANK_SCHED_PRIO_A_EN selects fixed A-over-B priority
// instead of round-robin arbitration (see rr_arb2).
// ---------------------------------------------------------------------------
module cmd_bank_sched
  import cmd_bank_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int CMD_W = 2,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  cmd_bank_sched_if.slave bus
);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] idx_reg, idx_next;
  logic [LEN_W-1:0] len_reg, len_next;
  src_t             src_reg, src_next;
  logic [CMD_W-1:0] active_reg [DEPTH-1:0];

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             idle;
  logic             issue;
  logic             hs_a;
  logic             hs_b;
  logic             hs;
  logic [LEN_W-1:0] sel_len;

  assign idle  = (state_reg == IDLE);
  assign issue = (state_reg == ISSUE);
  assign req   = {bus.b_valid, bus.a_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (hs),
    .gnt    (gnt)
  );

  // Ready is only offered from IDLE, so the active bank can never be
  // overwritten mid-issue. rst_n gates it so nothing is accepted in reset.
  assign bus.a_ready = rst_n && idle && gnt[0];
  assign bus.b_ready = rst_n && idle && gnt[1];

  assign hs_a = bus.a_valid && bus.a_ready;
  assign hs_b = bus.b_valid && bus.b_ready;
  assign hs   = hs_a || hs_b;

  assign sel_len = hs_b ? bus.b_len : bus.a_len;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    src_next   = src_reg;
    unique case (state_reg)
      IDLE: begin
        if (hs) begin
          src_next = hs_b ? SRC_B : SRC_A;
          // Lengths above the slot count are clamped to a full bank.
          len_next = LEN_W'(min_int(int'(sel_len), DEPTH));
          idx_next = '0;
          // An empty bank is still a grant but has nothing to issue.
          if (len_next != '0) begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.out_ready) begin
          if (idx_reg == len_reg - 1'b1) begin
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      len_reg    <= '0;
      src_reg    <= SRC_A;
      active_reg <= '{default: '0};
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
      src_reg   <= src_next;
      // Snapshot the whole bank so later input changes cannot leak in.
      if (hs_b) begin
        active_reg <= bus.b_bank;
      end else if (hs_a) begin
        active_reg <= bus.a_bank;
      end
    end
  end

  // Outputs are forced to zero outside ISSUE, which also covers reset.
  assign bus.busy      = issue;
  assign bus.out_valid = issue;
  assign bus.out_cmd   = issue ? active_reg[idx_reg] : '0;
  assign bus.out_idx   = issue ? idx_reg : '0;
  assign bus.out_src   = issue && (src_reg == SRC_B);

endmodule

// File: tb/tb_cmd_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_cmd_bank_sched
// Self-checking bench for cmd_bank_sched: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run against a
// queue-based reference model. Honors CMD_BANK_SCHED_PRIO_A_EN.
// ---------------------------------------------------------------------------
module tb_cmd_bank_sched;

  localparam int DEPTH = 9;
  localparam int CMD_W = 2;
  localparam int LEN_W = $clog2(DEPTH + 1);

`ifdef CMD_BANK_SCHED_PRIO_A_EN
  localparam bit PRIO_A = 1'b1;
`else
  localparam bit PRIO_A = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  cmd_bank_sched_if #(.DEPTH(DEPTH), .CMD_W(CMD_W), .LEN_W(LEN_W)) bus ();

  cmd_bank_sched #(.DEPTH(DEPTH), .CMD_W(CMD_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int cmd;
    int idx;
    int src;
  } item_t;

  item_t exp_q[$];   // commands the model says are still owed
  item_t seen_q[$];  // commands the DUT actually handed over
  bit    last_b;     // model: last grant went to B
  int    got_q[$];

  typedef struct {
    int av; int al; int bv; int bl; int rdy;
    int ar; int br; int ov; int cmd; int idx; int src; int busy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive_idle();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.a_len     = '0;
    bus.b_len     = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.a_bank[i] = '0;
      bus.b_bank[i] = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    seen_q.delete();
    last_b = 1'b1;
  endtask

  // Called at posedge+1; checks at posedge+2 and returns at next posedge+1.
  task automatic model_cycle();
    int    win;
    int    n;
    item_t it;
    #1;
    if (exp_q.size() == 0) begin
      win = 0;
      if (bus.a_valid && bus.b_valid) win = (PRIO_A || last_b) ? 1 : 2;
      else if (bus.a_valid)           win = 1;
      else if (bus.b_valid)           win = 2;
      chk("idle a_ready", bus.a_ready, win == 1);
      chk("idle b_ready", bus.b_ready, win == 2);
      chk("idle out_valid", bus.out_valid, 0);
      chk("idle busy", bus.busy, 0);
      if (win != 0) begin
        n = (win == 1) ? int'(bus.a_len) : int'(bus.b_len);
        if (n > DEPTH) n = DEPTH;
        for (int i = 0; i < n; i++) begin
          it.cmd = (win == 1) ? int'(bus.a_bank[i]) : int'(bus.b_bank[i]);
          it.idx = i;
          it.src = win - 1;
          exp_q.push_back(it);
        end
        last_b = (win == 2);
        $display("accept bank from %s len=%0d", (win == 1) ? "A" : "B", n);
      end
    end else begin
      chk("issue a_ready", bus.a_ready, 0);
      chk("issue b_ready", bus.b_ready, 0);
      chk("issue out_valid", bus.out_valid, 1);
      chk("issue busy", bus.busy, 1);
      chk("issue out_cmd", bus.out_cmd, exp_q[0].cmd);
      chk("issue out_idx", bus.out_idx, exp_q[0].idx);
      chk("issue out_src", bus.out_src, exp_q[0].src);
      if (bus.out_valid && bus.out_ready) begin
        it.cmd = int'(bus.out_cmd);
        it.idx = int'(bus.out_idx);
        it.src = int'(bus.out_src);
        seen_q.push_back(it);
      end
      if (bus.out_ready) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      model_cycle();
      c++;
    end
    chk("drain bound", exp_q.size(), 0);
    model_cycle();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " a_ready"}, bus.a_ready, 0);
    chk({tag, " b_ready"}, bus.b_ready, 0);
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " out_cmd"}, bus.out_cmd, 0);
    chk({tag, " out_idx"}, bus.out_idx, 0);
    chk({tag, " out_src"}, bus.out_src, 0);
  endtask

  // Resets with both requesters valid to show nothing is accepted in reset.
  task automatic apply_reset();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_len   = LEN_W'(3);
    bus.b_len   = LEN_W'(3);
    rst_n       = 1'b0;
    #1;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    #1;
    apply_reset();

    // ---------------- directed table ----------------
    //            av al bv bl rdy  ar br ov cmd idx src busy
    vecs[0]  = '{1, 4, 0, 0, 1,   1, 0, 0, 0,  0,  0,  0};
    vecs[1]  = '{0, 0, 0, 0, 1,   0, 0, 1, 3,  0,  0,  1};
    vecs[2]  = '{0, 0, 0, 0, 1,   0, 0, 1, 2,  1,  0,  1};
    vecs[3]  = '{0, 0, 0, 0, 1,   0, 0, 1, 1,  2,  0,  1};
    vecs[4]  = '{0, 0, 0, 0, 1,   0, 0, 1, 0,  3,  0,  1};
    vecs[5]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0,  0,  0,  0};
    vecs[6]  = '{0, 0, 1, 0, 1,   0, 1, 0, 0,  0,  0,  0};
    vecs[7]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0,  0,  0,  0};
    vecs[8]  = '{1, 1, 1, 2, 1,   1, 0, 0, 0,  0,  0,  0};
    vecs[9]  = '{0, 0, 1, 2, 1,   0, 0, 1, 3,  0,  0,  1};
    vecs[10] = '{0, 0, 1, 2, 1,   0, 1, 0, 0,  0,  0,  0};
    vecs[11] = '{0, 0, 0, 0, 0,   0, 0, 1, 2,  0,  1,  1};
    vecs[12] = '{0, 0, 0, 0, 0,   0, 0, 1, 2,  0,  1,  1};
    vecs[13] = '{0, 0, 0, 0, 1,   0, 0, 1, 2,  0,  1,  1};
    vecs[14] = '{0, 0, 0, 0, 1,   0, 0, 1, 1,  1,  1,  1};
    vecs[15] = '{0, 0, 0, 0, 1,   0, 0, 0, 0,  0,  0,  0};

    for (int i = 0; i < DEPTH; i++) begin
      bus.a_bank[i] = (i < 4) ? CMD_W'(3 - i) : CMD_W'(2);
      bus.b_bank[i] = (i == 0) ? CMD_W'(2) : ((i == 1) ? CMD_W'(1) : CMD_W'(3));
    end

    for (int r = 0; r < 16; r++) begin
      bus.a_valid   = vecs[r].av[0];
      bus.a_len     = LEN_W'(vecs[r].al);
      bus.b_valid   = vecs[r].bv[0];
      bus.b_len     = LEN_W'(vecs[r].bl);
      bus.out_ready = vecs[r].rdy[0];
      #1;
      chk($sformatf("row%0d a_ready", r), bus.a_ready, vecs[r].ar);
      chk($sformatf("row%0d b_ready", r), bus.b_ready, vecs[r].br);
      chk($sformatf("row%0d out_valid", r), bus.out_valid, vecs[r].ov);
      chk($sformatf("row%0d busy", r), bus.busy, vecs[r].busy);
      if (vecs[r].ov != 0) begin
        chk($sformatf("row%0d out_cmd", r), bus.out_cmd, vecs[r].cmd);
        chk($sformatf("row%0d out_idx", r), bus.out_idx, vecs[r].idx);
        chk($sformatf("row%0d out_src", r), bus.out_src, vecs[r].src);
      end
      $display("row %0d: a_ready=%0b b_ready=%0b out_valid=%0b cmd=%0d idx=%0d src=%0b",
               r, bus.a_ready, bus.b_ready, bus.out_valid, bus.out_cmd, bus.out_idx, bus.out_src);
      @(posedge clk);
      #1;
    end

    // ---------------- grant order with continuous contention ----------------
    apply_reset();
    bus.a_valid = 1'b1; bus.a_len = LEN_W'(2);
    bus.b_valid = 1'b1; bus.b_len = LEN_W'(2);
    got_q.delete();
    for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
      #1;
      if (bus.a_ready)      got_q.push_back(0);
      else if (bus.b_ready) got_q.push_back(1);
      @(posedge clk);
      #1;
    end
    chk("grant count", got_q.size(), 4);
    for (int g = 0; g < got_q.size(); g++) begin
      chk($sformatf("grant%0d src", g), got_q[g], PRIO_A ? 0 : (g % 2));
      $display("grant %0d to %s", g, (got_q[g] == 0) ? "A" : "B");
    end

    // ---------------- stall at idx 1 for three cycles ----------------
    apply_reset();
    bus.a_bank[0] = CMD_W'(1); bus.a_bank[1] = CMD_W'(2); bus.a_bank[2] = CMD_W'(3);
    bus.a_bank[3] = CMD_W'(0); bus.a_bank[4] = CMD_W'(2);
    bus.a_len = LEN_W'(5);
    bus.a_valid = 1'b1;
    model_cycle();
    bus.a_valid = 1'b0;
    bus.out_ready = 1'b1;
    model_cycle();
    bus.out_ready = 1'b0;
    repeat (3) model_cycle();
    bus.out_ready = 1'b1;
    drain(10);
    chk("stall issued count", seen_q.size(), 5);
    for (int k = 0; k < seen_q.size() && k < 5; k++) begin
      chk($sformatf("stall cmd%0d", k), seen_q[k].cmd, (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : (k == 3) ? 0 : 2);
      chk($sformatf("stall idx%0d", k), seen_q[k].idx, k);
    end

    // ---------------- over-long length is clamped ----------------
    apply_reset();
    for (int i = 0; i < DEPTH; i++) bus.a_bank[i] = CMD_W'((i * 3 + 1) % 4);
    bus.a_len = LEN_W'(15);
    bus.a_valid = 1'b1;
    model_cycle();
    bus.a_valid = 1'b0;
    drain(30);
    chk("clamp issued count", seen_q.size(), DEPTH);
    if (seen_q.size() != 0) chk("clamp last idx", seen_q[seen_q.size() - 1].idx, DEPTH - 1);

    // ---------------- reset in the middle of a bank ----------------
    apply_reset();
    bus.a_bank[0] = CMD_W'(1); bus.a_bank[1] = CMD_W'(2); bus.a_bank[2] = CMD_W'(3);
    bus.a_bank[3] = CMD_W'(1); bus.a_bank[4] = CMD_W'(2);
    bus.a_len = LEN_W'(5);
    bus.a_valid = 1'b1;
    model_cycle();
    bus.a_valid = 1'b0;
    model_cycle();
    model_cycle();
    #1;
    chk("pre-reset out_idx", bus.out_idx, 2);
    #1;
    bus.a_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid-issue reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    bus.a_bank[0] = CMD_W'(3); bus.a_bank[1] = CMD_W'(0);
    bus.a_len = LEN_W'(2);
    rst_n = 1'b1;
    model_cycle();
    bus.a_valid = 1'b0;
    drain(10);
    chk("post-reset count", seen_q.size(), 2);
    if (seen_q.size() != 0) begin
      chk("post-reset first idx", seen_q[0].idx, 0);
      chk("post-reset first cmd", seen_q[0].cmd, 3);
    end

    // ---------------- randomized run against the model ----------------
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.a_valid   = ($urandom_range(0, 1) == 1);
      bus.b_valid   = ($urandom_range(0, 1) == 1);
      bus.a_len     = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      bus.b_len     = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < DEPTH; i++) begin
        bus.a_bank[i] = CMD_W'($urandom_range(0, (1 << CMD_W) - 1));
        bus.b_bank[i] = CMD_W'($urandom_range(0, (1 << CMD_W) - 1));
      end
      model_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
